// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared types and constants for the RPN calculator input front-end
package rpn_pkg;

    localparam int OPCODE_WIDTH       = 2;
    localparam int DEFAULT_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_REL = 2'd2
    } fe_state_t;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rpn_input_frontend_if.sv
// rtl/rpn_input_frontend_if.sv - command bus from the input front-end to the calculator
interface rpn_input_frontend_if #(
    parameter int data_width = rpn_pkg::DEFAULT_DATA_WIDTH
);

    logic                              push;
    logic                              func;
    logic [data_width-1:0]             dataIn;
    logic [rpn_pkg::OPCODE_WIDTH-1:0]  ALU_opcode;
    logic                              busy;

    modport master (
        output push,
        output func,
        output dataIn,
        output ALU_opcode,
        output busy
    );

    modport slave (
        input push,
        input func,
        input dataIn,
        input ALU_opcode,
        input busy
    );

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser, stability counter and press pulse for one button
module button_debouncer
    import rpn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic [CW-1:0] cnt;

    // The level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/rpn_input_frontend.sv
// rtl/rpn_input_frontend.sv - button/switch front-end issuing one held command per press
module rpn_input_frontend
    import rpn_pkg::*;
#(
    parameter int data_width      = DEFAULT_DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_push_raw,
    input  logic                    btn_func_raw,
    input  logic [data_width-1:0]   sw_data,
    input  logic [OPCODE_WIDTH-1:0] sw_op,
    rpn_input_frontend_if.master    cmd
);

    localparam int             HW        = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic      level_push;
    logic      level_func;
    logic      rise_push;
    logic      rise_func;
    fe_state_t state;
    logic [HW-1:0] hold_cnt;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_push (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_push_raw),
        .level   (level_push),
        .rise    (rise_push)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_func (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_func_raw),
        .level   (level_func),
        .rise    (rise_func)
    );

    // Push wins a simultaneous press; presses outside IDLE are dropped, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            hold_cnt       <= '0;
            cmd.push       <= 1'b0;
            cmd.func       <= 1'b0;
            cmd.dataIn     <= '0;
            cmd.ALU_opcode <= '0;
            cmd.busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise_push || rise_func) begin
                        state          <= ST_ISSUE;
                        hold_cnt       <= '0;
                        cmd.push       <= rise_push;
                        cmd.func       <= ~rise_push;
                        cmd.dataIn     <= sw_data;
                        cmd.ALU_opcode <= sw_op;
                        cmd.busy       <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_WAIT_REL;
                        cmd.push <= 1'b0;
                        cmd.func <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_WAIT_REL: begin
                    if (!level_push && !level_func) begin
                        state    <= ST_IDLE;
                        cmd.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cmd.push <= 1'b0;
                    cmd.func <= 1'b0;
                    cmd.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_input_frontend.sv
// tb/tb_rpn_input_frontend.sv - self-checking bench for rpn_input_frontend
module tb_rpn_input_frontend;
    import rpn_pkg::*;

    localparam int DW   = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          bp      = 1'b0;
    logic          bf      = 1'b0;
    logic [DW-1:0] sw_data = '0;
    logic [1:0]    sw_op   = '0;

    rpn_input_frontend_if #(.data_width(DW)) cmd ();

    rpn_input_frontend #(
        .data_width      (DW),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_push_raw (bp),
        .btn_func_raw (bf),
        .sw_data      (sw_data),
        .sw_op        (sw_op),
        .cmd          (cmd)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a button level follows the synchronised input once the
    // last DEB synchronised samples all disagree with it; a press is a 0->1 level change.
    bit          m_s1   [2];
    bit          m_s2   [2];
    bit          m_lvl  [2];
    bit          m_lvlq [2];
    bit          m_hist [2][DEB];
    int          m_mode = 0;
    int          m_rem  = 0;
    logic        m_push = 1'b0;
    logic        m_func = 1'b0;
    logic        m_busy = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [1:0]  m_op   = '0;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvlq[b] = 0;
            for (int i = 0; i < DEB; i++) m_hist[b][i] = 0;
        end
        m_mode = 0; m_rem = 0;
        m_push = 0; m_func = 0; m_busy = 0; m_data = '0; m_op = '0;
    endtask

    task automatic model_step();
        bit rise_p, rise_f, smp, differ;
        bit raw [2];
        rise_p = m_lvl[0] && !m_lvlq[0];
        rise_f = m_lvl[1] && !m_lvlq[1];
        if (m_mode == 0) begin
            if (rise_p || rise_f) begin
                m_push = rise_p; m_func = !rise_p;
                m_data = sw_data; m_op = sw_op;
                m_busy = 1; m_rem = HOLD; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_push = 0; m_func = 0; m_mode = 2;
            end
        end else if (!m_lvl[0] && !m_lvl[1]) begin
            m_busy = 0; m_mode = 0;
        end
        raw[0] = bp;
        raw[1] = bf;
        for (int b = 0; b < 2; b++) begin
            smp = m_s2[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
            for (int i = DEB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
            m_hist[b][0] = smp;
            m_lvlq[b] = m_lvl[b];
            differ = 1;
            for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_lvl[b]) differ = 0;
            if (differ) m_lvl[b] = !m_lvl[b];
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    int   push_pulses = 0;
    int   func_pulses = 0;
    int   push_hi     = 0;
    int   func_hi     = 0;
    int   push_rise_cyc = 0;
    logic obs_push_q  = 1'b0;
    logic obs_func_q  = 1'b0;

    // Per-cycle compare against the model, plus pulse bookkeeping for literal checks.
    initial forever begin
        @(negedge clk);
        check("push",       {31'b0, cmd.push},       {31'b0, m_push});
        check("func",       {31'b0, cmd.func},       {31'b0, m_func});
        check("busy",       {31'b0, cmd.busy},       {31'b0, m_busy});
        check("dataIn",     {28'b0, cmd.dataIn},     {28'b0, m_data});
        check("ALU_opcode", {30'b0, cmd.ALU_opcode}, {30'b0, m_op});
        if (cmd.push && !obs_push_q) begin push_pulses++; push_rise_cyc = cyc; end
        if (cmd.func && !obs_func_q) func_pulses++;
        if (cmd.push) push_hi++;
        if (cmd.func) func_hi++;
        obs_push_q = cmd.push;
        obs_func_q = cmd.func;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (cmd.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'b0, cmd.busy}, 32'd0);
        wait_cycles(2);
    endtask

    int pp0, fp0, ph0, fh0, t0;

    task automatic snap();
        pp0 = push_pulses; fp0 = func_pulses; ph0 = push_hi; fh0 = func_hi;
    endtask

    initial begin
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
        check("rst_push",   {31'b0, cmd.push},   32'd0);
        check("rst_func",   {31'b0, cmd.func},   32'd0);
        check("rst_busy",   {31'b0, cmd.busy},   32'd0);
        check("rst_dataIn", {28'b0, cmd.dataIn}, 32'd0);
        check("rst_op",     {30'b0, cmd.ALU_opcode}, 32'd0);

        // Clean push with operand 9.
        sw_data = 4'h9;
        snap();
        t0 = cyc;
        bp = 1'b1;
        wait_cycles(20);
        check("clean_push_pulses", push_pulses - pp0, 32'd1);
        check("clean_push_len",    push_hi - ph0,     32'd3);
        check("clean_push_latency", push_rise_cyc - t0, 32'd7);
        check("clean_dataIn",      {28'b0, cmd.dataIn}, 32'd9);
        check("clean_held_busy",   {31'b0, cmd.busy}, 32'd1);
        bp = 1'b0;
        wait_cycles(6);
        check("release_busy_6", {31'b0, cmd.busy}, 32'd1);
        wait_cycles(1);
        check("release_busy_7", {31'b0, cmd.busy}, 32'd0);
        wait_cycles(3);

        // Bouncy func press with opcode 2.
        sw_op = 2'b10;
        snap();
        for (int i = 0; i < 5; i++) begin
            bf = (i % 2 == 0);
            wait_cycles(2);
        end
        bf = 1'b1;
        wait_cycles(20);
        check("bouncy_func_pulses", func_pulses - fp0, 32'd1);
        check("bouncy_func_len",    func_hi - fh0,     32'd3);
        check("bouncy_push_pulses", push_pulses - pp0, 32'd0);
        check("bouncy_opcode",      {30'b0, cmd.ALU_opcode}, 32'd2);
        bf = 1'b0;
        wait_idle("bouncy_idle");

        // Both buttons in the same cycle: push only.
        sw_data = 4'h5;
        snap();
        bp = 1'b1; bf = 1'b1;
        wait_cycles(20);
        check("both_push_pulses", push_pulses - pp0, 32'd1);
        check("both_push_len",    push_hi - ph0,     32'd3);
        check("both_func_pulses", func_pulses - fp0, 32'd0);
        bp = 1'b0; bf = 1'b0;
        wait_idle("both_idle");

        // Push held 50 cycles, func pressed during the hold.
        snap();
        bp = 1'b1;
        wait_cycles(20);
        bf = 1'b1;
        wait_cycles(30);
        bp = 1'b0;
        wait_cycles(10);
        check("hold_busy_func_held", {31'b0, cmd.busy}, 32'd1);
        bf = 1'b0;
        wait_cycles(6);
        check("hold_busy_6", {31'b0, cmd.busy}, 32'd1);
        wait_cycles(1);
        check("hold_busy_7", {31'b0, cmd.busy}, 32'd0);
        check("hold_push_pulses", push_pulses - pp0, 32'd1);
        check("hold_func_pulses", func_pulses - fp0, 32'd0);
        wait_cycles(3);

        // Operand changes during ISSUE only take effect on the next press.
        sw_data = 4'd3;
        bp = 1'b1;
        wait_cycles(8);
        check("chg_in_issue", {31'b0, cmd.push}, 32'd1);
        sw_data = 4'd12;
        wait_cycles(10);
        check("chg_hold_3", {28'b0, cmd.dataIn}, 32'd3);
        bp = 1'b0;
        wait_idle("chg_idle1");
        check("chg_idle_3", {28'b0, cmd.dataIn}, 32'd3);
        bp = 1'b1;
        wait_cycles(12);
        check("chg_new_12", {28'b0, cmd.dataIn}, 32'd12);
        bp = 1'b0;
        wait_idle("chg_idle2");

        // Reset asserted mid-ISSUE.
        sw_data = 4'd7;
        bp = 1'b1;
        wait_cycles(8);
        check("mid_issue_push", {31'b0, cmd.push}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_push", {31'b0, cmd.push}, 32'd0);
        check("async_rst_busy", {31'b0, cmd.busy}, 32'd0);
        bp = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        snap();
        wait_cycles(20);
        check("post_rst_pulses", push_pulses - pp0, 32'd0);
        check("post_rst_busy",   {31'b0, cmd.busy}, 32'd0);

        // Button held through reset release is issued once.
        rst_n = 1'b0;
        bp = 1'b1;
        wait_cycles(3);
        snap();
        rst_n = 1'b1;
        wait_cycles(25);
        check("held_rst_pulses", push_pulses - pp0, 32'd1);
        check("held_rst_len",    push_hi - ph0,     32'd3);
        bp = 1'b0;
        wait_idle("held_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
